// File: rtl/ram_win_arb_if.sv
// Bus bundle between the console bus masters and ram_win_arb, plus the single-port RAM side.
// Signal prefixes are given from the adapter's point of view.
interface ram_win_arb_if #(
  parameter int N_CH   = 2,
  parameter int RAM_AW = 11
);
  logic [N_CH-1:0]    i_req;
  logic [16*N_CH-1:0] i_addr;
  logic [N_CH-1:0]    i_wn;
  logic [8*N_CH-1:0]  i_wdata;
  logic [N_CH-1:0]    o_ack;
  logic [N_CH-1:0]    o_rvalid;
  logic [7:0]         o_rdata;
  logic [RAM_AW-1:0]  o_ram_addr;
  logic [7:0]         o_ram_din;
  logic               o_ram_r_wn;
  logic [7:0]         i_ram_q;

  modport slave (
    input  i_req, i_addr, i_wn, i_wdata, i_ram_q,
    output o_ack, o_rvalid, o_rdata, o_ram_addr, o_ram_din, o_ram_r_wn
  );

  modport master (
    output i_req, i_addr, i_wn, i_wdata, i_ram_q,
    input  o_ack, o_rvalid, o_rdata, o_ram_addr, o_ram_din, o_ram_r_wn
  );
endinterface

// File: rtl/ram_win_arb.sv
// Multi-master window-decoding adapter onto one single-port synchronous RAM.
// Define RAM_ARB_RR_EN for round-robin arbitration; otherwise lowest channel index wins.
module ram_win_arb #(
  parameter int                  N_CH     = 2,
  parameter int                  RAM_AW   = 11,
  parameter int                  WIN_LSB  = 13,
  parameter logic [15-WIN_LSB:0] WIN_BASE = '0,
  parameter int                  RD_LAT   = 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  ram_win_arb_if.slave bus
);
  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef struct packed {
    logic          vld;
    logic [CW-1:0] ch;
    logic          hit;
  } rd_slot_t;

  logic [N_CH-1:0]   r_ack;
  logic [N_CH-1:0]   r_rvalid;
  logic [7:0]        r_rdata;
  logic [RAM_AW-1:0] r_ram_addr;
  logic [7:0]        r_ram_din;
  logic              r_ram_r_wn;
  rd_slot_t [RD_LAT:0] r_pipe;

  logic [N_CH-1:0] w_elig;
  logic [N_CH-1:0] w_gnt_oh;
  logic [N_CH-1:0] w_exit_oh;
  logic            w_gnt_vld;
  logic [CW-1:0]   w_gnt_idx;
  logic [15:0]     w_addr;
  logic            w_wn;
  logic [7:0]      w_wdata;
  logic            w_hit;
  rd_slot_t        w_slot;
  rd_slot_t        w_exit;
  logic            w_unused;

  // A channel acked this cycle is still showing its old request; skip it.
  assign w_elig = bus.i_req & ~r_ack;

`ifdef RAM_ARB_RR_EN
  logic [CW-1:0] r_ptr;

  // Pick the eligible channel closest after the last one granted.
  always_comb begin
    int best;
    int dist;
    best      = N_CH;
    dist      = 0;
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    for (int k = 0; k < N_CH; k++) begin
      dist = (k + N_CH - 1 - int'(r_ptr)) % N_CH;
      if (w_elig[k] && dist < best) begin
        best      = dist;
        w_gnt_vld = 1'b1;
        w_gnt_idx = CW'(k);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr <= CW'(N_CH - 1);
    end else if (w_gnt_vld) begin
      r_ptr <= w_gnt_idx;
    end
  end
`else
  // NOTE: every variable gets a default before the branches, so no latch is inferred.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (w_elig[k]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = CW'(k);
      end
    end
  end
`endif

  always_comb begin
    w_addr   = '0;
    w_wn     = 1'b1;
    w_wdata  = '0;
    w_gnt_oh = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (w_gnt_idx == CW'(k)) begin
        w_addr      = bus.i_addr[16*k +: 16];
        w_wn        = bus.i_wn[k];
        w_wdata     = bus.i_wdata[8*k +: 8];
        w_gnt_oh[k] = w_gnt_vld;
      end
    end
  end

  assign w_hit    = (w_addr[15:WIN_LSB] == WIN_BASE);
  assign w_slot   = '{vld: w_gnt_vld & w_wn, ch: w_gnt_idx, hit: w_hit};
  assign w_exit   = r_pipe[RD_LAT];
  // Address bits between the fold and the window decode are mirror bits.
  assign w_unused = ^w_addr;

  always_comb begin
    w_exit_oh = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (w_exit.ch == CW'(k)) w_exit_oh[k] = w_exit.vld;
    end
  end

  // NOTE: state updates use non-blocking assignments, and the read pipeline is reset so
  // that reads in flight when reset hits never produce an rvalid.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ack      <= '0;
      r_rvalid   <= '0;
      r_rdata    <= 8'h00;
      r_ram_addr <= '0;
      r_ram_din  <= 8'h00;
      r_ram_r_wn <= 1'b1;
      r_pipe     <= '0;
    end else begin
      r_ack      <= w_gnt_oh;
      r_ram_r_wn <= 1'b1;
      if (w_gnt_vld) begin
        // A window miss becomes a dummy read of address 0.
        r_ram_addr <= w_hit ? w_addr[RAM_AW-1:0] : '0;
        r_ram_din  <= w_hit ? w_wdata : 8'h00;
        r_ram_r_wn <= w_hit ? w_wn : 1'b1;
      end
      r_pipe   <= {r_pipe[RD_LAT-1:0], w_slot};
      r_rvalid <= w_exit_oh;
      if (w_exit.vld) begin
        r_rdata <= w_exit.hit ? bus.i_ram_q : 8'h00;
      end
    end
  end

  assign bus.o_ack      = r_ack;
  assign bus.o_rvalid   = r_rvalid;
  assign bus.o_rdata    = r_rdata;
  assign bus.o_ram_addr = r_ram_addr;
  assign bus.o_ram_din  = r_ram_din;
  assign bus.o_ram_r_wn = r_ram_r_wn;
endmodule
